// File: rtl/neg_accumulate.sv
// neg_accumulate
//   Streaming signed add/subtract accumulator. Each accepted beat is extended
//   to accumulator width, optionally negated, and added into a saturating
//   accumulator. After an effective frame length of beats, the frame total is
//   registered onto a valid/ready output. It is held there until consumed.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clear      synchronous abort of the current frame and any pending result
//   len        beats per frame, sampled on the first beat of a frame (0 -> 1)
//   in_data    input sample (BW_IN bits, signedness set by IN_SIGNED)
//   in_sub     1 = subtract this sample, 0 = add it
//   in_valid   input beat valid
//   in_ready   registered; stage can accept a beat
//   out_data   signed frame total (BW_ACC bits)
//   out_sat    saturation happened at least once during the frame
//   out_valid  frame total valid
//   out_ready  downstream accepts the frame total
module neg_accumulate #(
  parameter int BW_IN     = 16,
  parameter int BW_ACC    = 32,
  parameter int LEN_BW    = 8,
  parameter int IN_SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [LEN_BW-1:0] len,
  input  logic [BW_IN-1:0]  in_data,
  input  logic              in_sub,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BW_ACC-1:0] out_data,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PAD_W = BW_ACC - BW_IN;
  localparam logic signed [BW_ACC-1:0] ACC_MAX = {1'b0, {(BW_ACC-1){1'b1}}};
  localparam logic signed [BW_ACC-1:0] ACC_MIN = {1'b1, {(BW_ACC-1){1'b0}}};
  localparam logic [LEN_BW-1:0] LEN_ONE = {{(LEN_BW-1){1'b0}}, 1'b1};
  localparam logic [LEN_BW:0]   CNT_ONE = {{LEN_BW{1'b0}}, 1'b1};

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  // The wide sum overflows the accumulator range exactly when its two top
  // bits disagree.
  function automatic logic sat_ovf(input logic signed [BW_ACC:0] s);
    return s[BW_ACC] ^ s[BW_ACC-1];
  endfunction

  function automatic logic signed [BW_ACC-1:0] sat_clip(input logic signed [BW_ACC:0] s);
    if (sat_ovf(s)) return s[BW_ACC] ? ACC_MIN : ACC_MAX;
    return s[BW_ACC-1:0];
  endfunction

  state_t                    state, state_n;
  logic signed [BW_ACC-1:0]  acc, acc_n;
  logic [LEN_BW:0]           cnt, cnt_n;
  logic                      sat_q, sat_n;
  logic [LEN_BW-1:0]         len_q, len_q_n;
  logic                      in_ready_n;
  logic                      out_valid_n;
  logic [BW_ACC-1:0]         out_data_n;
  logic                      out_sat_n;

  logic                      accept;
  logic                      first_beat;
  logic signed [BW_ACC-1:0]  ext_p0;
  logic signed [BW_ACC-1:0]  term_p0;
  logic signed [BW_ACC-1:0]  base_p0;
  logic signed [BW_ACC:0]    sum_p0;
  logic signed [BW_ACC-1:0]  res_p0;
  logic                      hit_p0;
  logic                      sat_acc_p0;
  logic [LEN_BW-1:0]         len_eff_in;
  logic [LEN_BW:0]           eff_len;
  logic [LEN_BW:0]           cnt_inc;

  assign accept     = in_valid && in_ready;
  assign first_beat = (cnt == '0);

  // Stage p0: extend, negate, accumulate and saturate the incoming beat
  always_comb begin
    ext_p0     = (IN_SIGNED != 0) ? {{PAD_W{in_data[BW_IN-1]}}, in_data}
                                  : {{PAD_W{1'b0}}, in_data};
    term_p0    = in_sub ? -ext_p0 : ext_p0;
    base_p0    = first_beat ? '0 : acc;
    sum_p0     = {base_p0[BW_ACC-1], base_p0} + {term_p0[BW_ACC-1], term_p0};
    hit_p0     = sat_ovf(sum_p0);
    res_p0     = sat_clip(sum_p0);
    sat_acc_p0 = (first_beat ? 1'b0 : sat_q) | hit_p0;
    len_eff_in = (len == '0) ? LEN_ONE : len;
    // The first beat compares against the length being sampled right now.
    eff_len    = first_beat ? {1'b0, len_eff_in} : {1'b0, len_q};
    cnt_inc    = cnt + CNT_ONE;
  end

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    sat_n       = sat_q;
    len_q_n     = len_q;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_sat_n   = out_sat;
    if (clear) begin
      state_n     = ST_ACC;
      acc_n       = '0;
      cnt_n       = '0;
      sat_n       = 1'b0;
      in_ready_n  = 1'b1;
      out_valid_n = 1'b0;
      out_data_n  = '0;
      out_sat_n   = 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          // in_ready comes up on the first edge after reset is released.
          in_ready_n = 1'b1;
          if (accept) begin
            if (first_beat) len_q_n = len_eff_in;
            if (cnt_inc == eff_len) begin
              state_n     = ST_OUT;
              in_ready_n  = 1'b0;
              out_valid_n = 1'b1;
              out_data_n  = res_p0;
              out_sat_n   = sat_acc_p0;
              acc_n       = '0;
              cnt_n       = '0;
              sat_n       = 1'b0;
            end else begin
              acc_n = res_p0;
              cnt_n = cnt_inc;
              sat_n = sat_acc_p0;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_n     = ST_ACC;
            in_ready_n  = 1'b1;
            out_valid_n = 1'b0;
            acc_n       = '0;
            cnt_n       = '0;
            sat_n       = 1'b0;
          end
        end
        default: begin
          state_n     = ST_ACC;
          in_ready_n  = 1'b0;
          out_valid_n = 1'b0;
        end
      endcase
    end
  end

  // Stage p1: frame state and registered output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      sat_q     <= 1'b0;
      len_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      sat_q     <= sat_n;
      len_q     <= len_q_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_sat   <= out_sat_n;
    end
  end

endmodule

// File: tb/tb_neg_accumulate.sv
// tb_neg_accumulate
//   Directed bench for neg_accumulate. Instance dut uses a 20-bit signed
//   accumulator; instance dut_u uses the default 32-bit accumulator with
//   unsigned input.
module tb_neg_accumulate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               clear;
  logic [7:0]         len;
  logic signed [15:0] in_data;
  logic               in_sub;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] out_data;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;

  logic               u_clear;
  logic [7:0]         u_len;
  logic [15:0]        u_in_data;
  logic               u_in_sub;
  logic               u_in_valid;
  logic               u_in_ready;
  logic signed [31:0] u_out_data;
  logic               u_out_sat;
  logic               u_out_valid;
  logic               u_out_ready;

  int n_chk = 0;
  int n_err = 0;

  neg_accumulate #(.BW_IN(16), .BW_ACC(20), .LEN_BW(8), .IN_SIGNED(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .len(len), .in_data(in_data),
    .in_sub(in_sub), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  neg_accumulate #(.BW_IN(16), .BW_ACC(32), .LEN_BW(8), .IN_SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .clear(u_clear), .len(u_len), .in_data(u_in_data),
    .in_sub(u_in_sub), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .out_data(u_out_data), .out_sat(u_out_sat), .out_valid(u_out_valid),
    .out_ready(u_out_ready)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the edge that accepts it.
  task automatic send(input int d, input logic s);
    in_data  = d[15:0];
    in_sub   = s;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    chk("beat_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input int d, input logic s);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_sat"}, out_sat, s);
    chk({tag, "_irdy"}, in_ready, 0);
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("take_vld", out_valid, 0);
    chk("take_irdy", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clear = 1'b0; len = '0; in_data = '0; in_sub = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    u_clear = 1'b0; u_len = '0; u_in_data = '0; u_in_sub = 1'b0;
    u_in_valid = 1'b0; u_out_ready = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_irdy", in_ready, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", out_sat, 0);
    tick(); tick();
    rst = 1'b0;
    chk("rel_irdy0", in_ready, 0);
    tick();
    chk("rel_irdy1", in_ready, 1);
    chk("rel_u_irdy1", u_in_ready, 1);

    // Add/subtract mix: 5 - 3 - 7 + 2 = -3
    len = 8'd4;
    send(5, 0); send(-3, 0); send(7, 1);
    chk("mix_vld_early", out_valid, 0);
    send(-2, 1);
    expect_res("mix", -3, 0);
    take();

    // Positive saturation: 20 * 32767 = 655340 > 524287
    len = 8'd20;
    for (int i = 0; i < 20; i++) send(32767, 0);
    expect_res("satp", 524287, 1);
    take();
    len = 8'd1;
    send(1, 0);
    expect_res("after_sat", 1, 0);
    take();

    // Negative saturation: -655340 < -524288
    len = 8'd20;
    for (int i = 0; i < 20; i++) send(32767, 1);
    expect_res("satn", -524288, 1);
    take();

    // Backpressure: 10 - 20 = -10, held while upstream keeps offering 99
    len = 8'd2;
    send(10, 0); send(20, 1);
    expect_res("bp", -10, 0);
    in_data = 16'sd99; in_sub = 1'b0; in_valid = 1'b1; len = 8'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_hold_data", out_data, -10);
      chk("bp_hold_irdy", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_rel_vld", out_valid, 0);
    chk("bp_rel_irdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    expect_res("bp_next", 99, 0);
    take();

    // len = 0 behaves as 1
    len = 8'd0;
    send(7, 0);
    expect_res("len0_a", 7, 0);
    take();
    send(-8, 1);
    expect_res("len0_b", 8, 0);
    take();

    // len change mid-frame is ignored: 1 + 2 + 3
    len = 8'd3;
    send(1, 0);
    len = 8'd1;
    send(2, 0);
    chk("lenchg_vld_early", out_valid, 0);
    send(3, 0);
    expect_res("lenchg", 6, 0);
    take();

    // Zero sample with subtract contributes nothing
    len = 8'd2;
    send(0, 1); send(12, 0);
    expect_res("zero_sub", 12, 0);
    take();

    // clear mid-frame drops the simultaneous beat
    len = 8'd4;
    send(1, 0); send(1, 0);
    in_data = 16'sd100; in_sub = 1'b0; in_valid = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_vld", out_valid, 0);
    chk("clr_irdy", in_ready, 1);
    send(1, 0); send(1, 0); send(1, 0);
    chk("clr_vld_early", out_valid, 0);
    send(1, 0);
    expect_res("clr_new", 4, 0);

    // clear while a result is pending
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_out_vld", out_valid, 0);
    chk("clr_out_data", out_data, 0);
    chk("clr_out_irdy", in_ready, 1);

    // rst while out_valid
    len = 8'd1;
    send(5, 0);
    chk("rstmid_vld1", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_vld0", out_valid, 0);
    chk("rstmid_irdy", in_ready, 0);
    chk("rstmid_data", out_data, 0);
    tick();
    rst = 1'b0;
    chk("rstmid_rel_irdy0", in_ready, 0);
    tick();
    chk("rstmid_rel_irdy1", in_ready, 1);

    // Unsigned input: -65535 + 1 = -65534
    u_len = 8'd2;
    u_in_data = 16'hFFFF; u_in_sub = 1'b1; u_in_valid = 1'b1;
    chk("u_irdy", u_in_ready, 1);
    tick();
    u_in_data = 16'h0001; u_in_sub = 1'b0;
    tick();
    u_in_valid = 1'b0;
    chk("u_vld", u_out_valid, 1);
    chk("u_data", u_out_data, -65534);
    chk("u_sat", u_out_sat, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
